// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols, receive alignment states and
// the 10b->8b data decode used by the lane receiver (the transmit encoder
// imports this package too).
package tmds_pkg;

  localparam logic [9:0] TMDS_CTL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } align_state_t;

  // Undo the optional bit inversion (bit 9), then undo the XOR/XNOR chain
  // selected by bit 8.
  function automatic logic [7:0] tmds_decode8(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] q;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q    = '0;
    q[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_rx_align.sv
// Word-alignment FSM for one TMDS lane: counts control-token runs to declare
// lock, issues a bitslip after a hunt timeout, waits for the deserializer to
// settle, and drops lock after a long absence of control tokens.
module tmds_rx_align
  import tmds_pkg::*;
#(
  parameter int unsigned CTL_RUN      = 64,
  parameter int unsigned HUNT_TIMEOUT = 2048,
  parameter int unsigned SLIP_WAIT    = 16,
  parameter int unsigned LOSS_TIMEOUT = 1048576
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sym_vld,
  input  logic i_is_ctl,
  output logic o_bitslip,
  output logic o_locked
);

  localparam int unsigned RUN_W  = $clog2(CTL_RUN + 1);
  localparam int unsigned TMO_W  = $clog2(HUNT_TIMEOUT + 1);
  localparam int unsigned SET_W  = $clog2(SLIP_WAIT + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(CTL_RUN);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(HUNT_TIMEOUT);
  localparam logic [SET_W-1:0]  SET_MAX  = SET_W'(SLIP_WAIT);
  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_TIMEOUT);

  align_state_t r_state, w_state;
  logic [RUN_W-1:0]  r_run,    w_run,    w_run_inc;
  logic [TMO_W-1:0]  r_tmo,    w_tmo,    w_tmo_inc;
  logic [SET_W-1:0]  r_settle, w_settle, w_settle_inc;
  logic [LOSS_W-1:0] r_loss,   w_loss,   w_loss_inc;
  logic              r_bitslip, w_slip;

  // Saturating increments: counters stop at their terminal value.
  assign w_run_inc    = (r_run    == RUN_MAX)  ? r_run    : r_run    + 1'b1;
  assign w_tmo_inc    = (r_tmo    == TMO_MAX)  ? r_tmo    : r_tmo    + 1'b1;
  assign w_settle_inc = (r_settle == SET_MAX)  ? r_settle : r_settle + 1'b1;
  assign w_loss_inc   = (r_loss   == LOSS_MAX) ? r_loss   : r_loss   + 1'b1;

  // State, counters and the one-cycle bitslip pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= HUNT;
      r_run     <= '0;
      r_tmo     <= '0;
      r_settle  <= '0;
      r_loss    <= '0;
      r_bitslip <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_run     <= w_run;
      r_tmo     <= w_tmo;
      r_settle  <= w_settle;
      r_loss    <= w_loss;
      r_bitslip <= w_slip;
    end
  end

  // Next state and counter updates; nothing advances without a valid symbol.
  always_comb begin
    w_state  = r_state;
    w_run    = r_run;
    w_tmo    = r_tmo;
    w_settle = r_settle;
    w_loss   = r_loss;
    w_slip   = 1'b0;
    if (i_sym_vld) begin
      unique case (r_state)
        HUNT: begin
          w_run = i_is_ctl ? w_run_inc : '0;
          w_tmo = w_tmo_inc;
          // A run match on the same symbol as the timeout wins: lock, no slip.
          if (i_is_ctl && (w_run_inc == RUN_MAX)) begin
            w_state = LOCKED;
            w_loss  = '0;
          end else if (w_tmo_inc == TMO_MAX) begin
            w_state = SLIP;
            w_slip  = 1'b1;
          end
        end
        SLIP: begin
          w_state  = SETTLE;
          w_settle = '0;
        end
        SETTLE: begin
          if (r_settle == SET_MAX) begin
            w_state = HUNT;
            w_run   = '0;
            w_tmo   = '0;
          end else begin
            w_settle = w_settle_inc;
          end
        end
        LOCKED: begin
          w_loss = i_is_ctl ? '0 : w_loss_inc;
          if (!i_is_ctl && (w_loss_inc == LOSS_MAX)) begin
            w_state = HUNT;
            w_run   = '0;
            w_tmo   = '0;
          end
        end
        default: w_state = HUNT;
      endcase
    end
  end

  assign o_bitslip = r_bitslip;
  assign o_locked  = (r_state == LOCKED);

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive lane: two-stage decode pipeline (classify, then decode)
// plus lane alignment. Define TMDS_RX_ALIGN_EN to build the bitslip FSM;
// without it the lane expects a self-aligning deserializer, bitslip_o is 0
// and locked_o sets on the first control token after reset.
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int unsigned CTL_RUN      = 64,
  parameter int unsigned HUNT_TIMEOUT = 2048,
  parameter int unsigned SLIP_WAIT    = 16,
  parameter int unsigned LOSS_TIMEOUT = 1048576
) (
  input  logic       clk_pix,
  input  logic       reset_n,
  input  logic [9:0] sym_i,
  input  logic       sym_valid_i,
  output logic [7:0] data_o,
  output logic [1:0] ctl_o,
  output logic       de_o,
  output logic       valid_o,
  output logic       bitslip_o,
  output logic       locked_o
);

  logic       w_is_ctl;
  logic [1:0] w_ctl;

  logic       r_vld1;
  logic [9:0] r_sym1;
  logic       r_is_ctl1;
  logic [1:0] r_ctl1;

  logic       r_vld2;
  logic [7:0] r_data2;
  logic [1:0] r_ctl2;
  logic       r_de2;

  // Classify the incoming symbol against the four control tokens (all 10 bits).
  always_comb begin
    w_is_ctl = 1'b1;
    w_ctl    = 2'b00;
    unique case (sym_i)
      TMDS_CTL_00: w_ctl = 2'b00;
      TMDS_CTL_01: w_ctl = 2'b01;
      TMDS_CTL_10: w_ctl = 2'b10;
      TMDS_CTL_11: w_ctl = 2'b11;
      default:     w_is_ctl = 1'b0;
    endcase
  end

  // Stage 1: capture symbol and token class on valid input.
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_vld1    <= 1'b0;
      r_sym1    <= '0;
      r_is_ctl1 <= 1'b0;
      r_ctl1    <= '0;
    end else begin
      r_vld1 <= sym_valid_i;
      if (sym_valid_i) begin
        r_sym1    <= sym_i;
        r_is_ctl1 <= w_is_ctl;
        r_ctl1    <= w_ctl;
      end
    end
  end

  // Stage 2: control tokens update ctl and hold data; data symbols do the reverse.
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_vld2  <= 1'b0;
      r_data2 <= '0;
      r_ctl2  <= '0;
      r_de2   <= 1'b0;
    end else begin
      r_vld2 <= r_vld1;
      if (r_vld1) begin
        if (r_is_ctl1) begin
          r_ctl2 <= r_ctl1;
          r_de2  <= 1'b0;
        end else begin
          r_data2 <= tmds_decode8(r_sym1);
          r_de2   <= 1'b1;
        end
      end
    end
  end

  assign data_o  = r_data2;
  assign ctl_o   = r_ctl2;
  assign de_o    = r_de2;
  assign valid_o = r_vld2;

`ifdef TMDS_RX_ALIGN_EN
  // The FSM consumes stage-1 symbols so lock changes land with stage-2 output.
  tmds_rx_align #(
    .CTL_RUN      (CTL_RUN),
    .HUNT_TIMEOUT (HUNT_TIMEOUT),
    .SLIP_WAIT    (SLIP_WAIT),
    .LOSS_TIMEOUT (LOSS_TIMEOUT)
  ) u_align (
    .i_clk     (clk_pix),
    .i_rst_n   (reset_n),
    .i_sym_vld (r_vld1),
    .i_is_ctl  (r_is_ctl1),
    .o_bitslip (bitslip_o),
    .o_locked  (locked_o)
  );
`else
  logic r_locked;
  logic w_unused_cfg;

  // Sticky lock on the first valid control token after reset.
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_locked <= 1'b0;
    end else if (r_vld1 && r_is_ctl1) begin
      r_locked <= 1'b1;
    end
  end

  assign locked_o     = r_locked;
  assign bitslip_o    = 1'b0;
  assign w_unused_cfg = ^{CTL_RUN, HUNT_TIMEOUT, SLIP_WAIT, LOSS_TIMEOUT};
`endif

endmodule

// File: tb/tb_tmds_rx_channel.sv
module tb_tmds_rx_channel;

  localparam int unsigned P_CTL_RUN   = 24;
  localparam int unsigned P_HUNT      = 32;
  localparam int unsigned P_SLIP_WAIT = 4;
  localparam int unsigned P_LOSS      = 100;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [1:0] c;
    logic       de;
    logic       lk;
    logic       sl;
  } snap_t;

  logic       clk;
  logic       reset_n;
  logic [9:0] sym_i;
  logic       sym_valid_i;
  logic [7:0] data_o;
  logic [1:0] ctl_o;
  logic       de_o;
  logic       valid_o;
  logic       bitslip_o;
  logic       locked_o;

  int n_checks;
  int n_err;

  logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  snap_t m_last;
  snap_t exp_prev;
  int    m_run, m_since, m_blind, m_loss;
  bit    m_locked;
  bit    rt_pend, rt_prev_pend;
  logic [7:0] rt_byte, rt_prev_byte;

  tmds_rx_channel #(
    .CTL_RUN      (P_CTL_RUN),
    .HUNT_TIMEOUT (P_HUNT),
    .SLIP_WAIT    (P_SLIP_WAIT),
    .LOSS_TIMEOUT (P_LOSS)
  ) dut (
    .clk_pix     (clk),
    .reset_n     (reset_n),
    .sym_i       (sym_i),
    .sym_valid_i (sym_valid_i),
    .data_o      (data_o),
    .ctl_o       (ctl_o),
    .de_o        (de_o),
    .valid_o     (valid_o),
    .bitslip_o   (bitslip_o),
    .locked_o    (locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] d, x;
    d = s[9] ? ~s[7:0] : s[7:0];
    x = d ^ (d << 1);
    if (!s[8]) x = ~x;
    x[0] = d[0];
    return x;
  endfunction

  // DVI transition-minimising encoder; inv selects the bit-9 inversion.
  function automatic logic [9:0] ref_encode(input logic [7:0] b, input logic inv);
    int         n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = $countones(b);
    use_xnor = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
    q        = '0;
    q[0]     = b[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
    q[8] = ~use_xnor;
    return {inv, q[8], inv ? ~q[7:0] : q[7:0]};
  endfunction

  task automatic model_reset();
    m_last   = '0;
    exp_prev = '0;
    m_run    = 0;
    m_since  = 0;
    m_blind  = 0;
    m_loss   = 0;
    m_locked = 0;
    rt_pend      = 0;
    rt_prev_pend = 0;
  endtask

  task automatic model_sym(input logic [9:0] s, output snap_t o);
    int    idx;
    snap_t cur;
    idx = -1;
    for (int i = 0; i < 4; i++) if (s == TOK[i]) idx = i;
    cur    = m_last;
    cur.v  = 1'b1;
    cur.sl = 1'b0;
    if (idx >= 0) begin
      cur.c  = 2'(idx);
      cur.de = 1'b0;
    end else begin
      cur.d  = ref_decode(s);
      cur.de = 1'b1;
    end
`ifdef TMDS_RX_ALIGN_EN
    if (m_blind > 0) begin
      m_blind--;
      if (m_blind == 0) begin
        m_run   = 0;
        m_since = 0;
      end
    end else if (!m_locked) begin
      m_since++;
      m_run = (idx >= 0) ? m_run + 1 : 0;
      if (m_run >= int'(P_CTL_RUN)) begin
        m_locked = 1;
        m_loss   = 0;
      end else if (m_since >= int'(P_HUNT)) begin
        cur.sl  = 1'b1;
        m_blind = int'(P_SLIP_WAIT) + 2;
      end
    end else begin
      if (idx >= 0) m_loss = 0;
      else m_loss++;
      if (m_loss >= int'(P_LOSS)) begin
        m_locked = 0;
        m_run    = 0;
        m_since  = 0;
      end
    end
`else
    if (idx >= 0) m_locked = 1;
`endif
    cur.lk = m_locked;
    m_last = cur;
    o      = cur;
  endtask

  task automatic step(input logic [9:0] s, input logic v);
    snap_t cur;
    if (v) model_sym(s, cur);
    else begin
      cur    = m_last;
      cur.v  = 1'b0;
      cur.sl = 1'b0;
    end
    sym_i       = s;
    sym_valid_i = v;
    @(posedge clk);
    #1;
    chk("valid_o",   valid_o,   exp_prev.v);
    chk("data_o",    data_o,    exp_prev.d);
    chk("ctl_o",     ctl_o,     exp_prev.c);
    chk("de_o",      de_o,      exp_prev.de);
    chk("locked_o",  locked_o,  exp_prev.lk);
    chk("bitslip_o", bitslip_o, exp_prev.sl);
    if (rt_prev_pend) chk("roundtrip", data_o, rt_prev_byte);
    rt_prev_pend = rt_pend && v;
    rt_prev_byte = rt_byte;
    rt_pend      = 0;
    exp_prev     = cur;
  endtask

  task automatic do_reset();
    sym_valid_i = 1'b0;
    reset_n     = 1'b0;
    #1;
    chk("rst_data",    data_o,    0);
    chk("rst_ctl",     ctl_o,     0);
    chk("rst_de",      de_o,      0);
    chk("rst_valid",   valid_o,   0);
    chk("rst_bitslip", bitslip_o, 0);
    chk("rst_locked",  locked_o,  0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int last_pulse, n_pulse;
    bit prev_bs;
    n_checks    = 0;
    n_err       = 0;
    reset_n     = 1'b1;
    sym_valid_i = 1'b0;
    sym_i       = '0;
    model_reset();
    #2;
    do_reset();

    // Directed control and data decode
    step(10'h354, 1'b1);
    step(10'h0AB, 1'b1);
    step(10'h154, 1'b1);
    step(10'h2AB, 1'b1);
    step(10'h100, 1'b1);
    chk("dir_ctl11", ctl_o, 2'b11);
    chk("dir_ctl_de", de_o, 1'b0);
    step(10'h2FF, 1'b1);
    chk("dir_100", data_o, 8'h00);
    chk("dir_100_de", de_o, 1'b1);
    step(10'h1FF, 1'b1);
    step(10'h000, 1'b0);
    chk("dir_1ff", data_o, 8'h01);
    step(10'h000, 1'b0);

    // Round trip of every byte through the reference encoder
    for (int b = 0; b < 256; b++) begin
      rt_pend = 1;
      rt_byte = 8'(b);
      step(ref_encode(8'(b), 1'($urandom_range(0, 1))), 1'b1);
    end
    step(10'h000, 1'b0);

    // Lock threshold
    do_reset();
`ifdef TMDS_RX_ALIGN_EN
    repeat (P_CTL_RUN - 1) step(10'h354, 1'b1);
    step(10'h100, 1'b1);
    step(10'h000, 1'b0);
    step(10'h000, 1'b0);
    chk("no_lock_short_run", locked_o, 1'b0);
    do_reset();
    repeat (P_CTL_RUN) step(10'h0AB, 1'b1);
    chk("lock_before_last", locked_o, 1'b0);
    step(10'h000, 1'b0);
    chk("lock_on_last", locked_o, 1'b1);
`else
    repeat (3) step(10'h100, 1'b1);
    step(10'h000, 1'b0);
    chk("no_lock_data_only", locked_o, 1'b0);
    step(10'h154, 1'b1);
    step(10'h000, 1'b0);
    chk("lock_first_ctl", locked_o, 1'b1);
`endif

    // Stall in the middle of a control run
    do_reset();
    repeat (10) step(10'h354, 1'b1);
    repeat (5) step(10'h354, 1'b0);
    repeat (P_CTL_RUN - 10) step(10'h354, 1'b1);
    step(10'h000, 1'b0);
    chk("lock_across_stall", locked_o, 1'b1);

    // Loss of lock after a long data stretch
    repeat (P_LOSS - 1) step(10'h100, 1'b1);
    step(10'h000, 1'b0);
    chk("loss_not_yet", locked_o, 1'b1);
    step(10'h100, 1'b1);
    step(10'h000, 1'b0);
`ifdef TMDS_RX_ALIGN_EN
    chk("loss_unlock", locked_o, 1'b0);
`else
    chk("sticky_lock", locked_o, 1'b1);
`endif

    // Random bursty traffic with stalls
    do_reset();
    for (int blk = 0; blk < 14; blk++) begin
      for (int k = 0; k < 30; k++) begin
        logic [9:0] s;
        if ($urandom_range(0, 99) < ((blk % 2 == 1) ? 96 : 15)) s = TOK[$urandom_range(0, 3)];
        else s = 10'($urandom_range(0, 1023));
        step(s, $urandom_range(0, 9) != 0);
      end
    end

    // Slip cadence with constant data, then reset while settling
    do_reset();
    last_pulse = -1;
    n_pulse    = 0;
    prev_bs    = 1'b0;
    for (int k = 0; k < 112; k++) begin
      step(10'h100, 1'b1);
      if (bitslip_o === 1'b1) begin
        chk("slip_width", prev_bs, 1'b0);
        if (last_pulse >= 0) chk("slip_period", k - last_pulse, P_HUNT + P_SLIP_WAIT + 2);
        last_pulse = k;
        n_pulse++;
      end
      prev_bs = bitslip_o;
    end
`ifdef TMDS_RX_ALIGN_EN
    chk("slip_count", n_pulse, 3);
`else
    chk("slip_count", n_pulse, 0);
`endif
    do_reset();
    repeat (P_CTL_RUN) step(10'h2AB, 1'b1);
    step(10'h000, 1'b0);
    chk("lock_after_reset", locked_o, 1'b1);
    step(10'h000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
